// File: rtl/fifo_ctrl_pkg.sv
// Shared types and constants for the push-button FIFO controller.
// Optional feature macro used by the controller: FIFO_LEVEL_TRACK_EN.
package fifo_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        READ    = 2'd2,
        RD_WAIT = 2'd3
    } state_t;

    localparam logic PRIO_WR = 1'b0;
    localparam logic PRIO_RD = 1'b1;

    localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/req_edge_latch.sv
// Turns a stretched button level into a single pending request bit.
// A held level only ever produces one request; a new press needs a release first.
module req_edge_latch (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    input  logic i_clr,
    output logic o_pend
);

    logic r_btn_q;
    logic r_pend;
    logic w_rise;

    assign w_rise = i_btn & ~r_btn_q;
    assign o_pend = r_pend;

    // Remember the previous button level and hold a request until it is served or rejected
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_btn_q <= 1'b0;
            r_pend  <= 1'b0;
        end else begin
            r_btn_q <= i_btn;
            r_pend  <= (r_pend & ~i_clr) | w_rise;
        end
    end

endmodule

// File: rtl/fifo_button_ctrl.sv
// Sequences FIFO write/read strobes from debounced push-button requests,
// arbitrates simultaneous presses, captures read data for display and
// keeps sticky reject flags.
// Optional feature macro: FIFO_LEVEL_TRACK_EN (adds ADDR_W and o_level,
// and gates grants on the tracked occupancy as well as full/empty).
module fifo_button_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
`ifdef FIFO_LEVEL_TRACK_EN
    parameter int ADDR_W = 4,
`endif
    parameter int RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr_btn,
    input  logic              i_rd_btn,
    input  logic [DATA_W-1:0] i_sw_data,
    input  logic              i_full,
    input  logic              i_empty,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic              o_wr_en,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_rd_en,
    output logic [DATA_W-1:0] o_disp_data,
    output logic              o_disp_valid,
    output logic              o_err_full,
    output logic              o_err_empty,
`ifdef FIFO_LEVEL_TRACK_EN
    output logic [ADDR_W:0]   o_level,
`endif
    output logic              o_busy
);

    localparam logic [1:0] LAT_INIT = 2'(RD_LAT);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_prio;
    logic [DATA_W-1:0]  r_wr_data;
    logic [DATA_W-1:0]  r_disp_data;
    logic               r_disp_valid;
    logic               r_err_full;
    logic               r_err_empty;
    logic [1:0]         r_lat_cnt;

    logic               w_wr_pend;
    logic               w_rd_pend;
    logic               w_wr_clr;
    logic               w_rd_clr;
    logic               w_pick_wr;
    logic               w_pick_rd;
    logic               w_grant_wr;
    logic               w_set_err_full;
    logic               w_set_err_empty;
    logic               w_toggle_prio;
    logic               w_block_wr;
    logic               w_block_rd;

    req_edge_latch u_wr_req (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_wr_btn),
        .i_clr   (w_wr_clr),
        .o_pend  (w_wr_pend)
    );

    req_edge_latch u_rd_req (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_rd_btn),
        .i_clr   (w_rd_clr),
        .o_pend  (w_rd_pend)
    );

`ifdef FIFO_LEVEL_TRACK_EN
    localparam logic [ADDR_W:0] LEVEL_MAX = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W:0] r_level;

    assign o_level    = r_level;
    assign w_block_wr = i_full  | (r_level == LEVEL_MAX);
    assign w_block_rd = i_empty | (r_level == '0);

    // Track FIFO occupancy from our own strobes, saturating at both ends
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_level <= '0;
        end else if (o_wr_en && (r_level != LEVEL_MAX)) begin
            r_level <= r_level + 1'b1;
        end else if (o_rd_en && (r_level != '0)) begin
            r_level <= r_level - 1'b1;
        end
    end
`else
    assign w_block_wr = i_full;
    assign w_block_rd = i_empty;
`endif

    // When both sides are pending the priority bit decides; otherwise the lone request wins
    assign w_pick_wr = w_wr_pend & (~w_rd_pend | (r_prio == PRIO_WR));
    assign w_pick_rd = w_rd_pend & ~w_pick_wr;

    // Strobes are suppressed combinationally during reset so an aborted cycle never strobes
    assign o_wr_en      = (r_state == WRITE) & ~i_reset;
    assign o_rd_en      = (r_state == READ)  & ~i_reset;
    assign o_wr_data    = r_wr_data;
    assign o_disp_data  = r_disp_data;
    assign o_disp_valid = r_disp_valid;
    assign o_err_full   = r_err_full;
    assign o_err_empty  = r_err_empty;
    assign o_busy       = (r_state != IDLE);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: grant, reject or sequence through the single-cycle strobe states
    always_comb begin
        w_state_next    = r_state;
        w_wr_clr        = 1'b0;
        w_rd_clr        = 1'b0;
        w_grant_wr      = 1'b0;
        w_set_err_full  = 1'b0;
        w_set_err_empty = 1'b0;
        w_toggle_prio   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_wr) begin
                    w_toggle_prio = w_rd_pend;
                    if (w_block_wr) begin
                        w_set_err_full = 1'b1;
                        w_wr_clr       = 1'b1;
                    end else begin
                        w_grant_wr   = 1'b1;
                        w_state_next = WRITE;
                    end
                end else if (w_pick_rd) begin
                    w_toggle_prio = w_wr_pend;
                    if (w_block_rd) begin
                        w_set_err_empty = 1'b1;
                        w_rd_clr        = 1'b1;
                    end else begin
                        w_state_next = READ;
                    end
                end
            end
            WRITE: begin
                w_wr_clr     = 1'b1;
                w_state_next = IDLE;
            end
            READ: begin
                w_rd_clr     = 1'b1;
                w_state_next = RD_WAIT;
            end
            RD_WAIT: begin
                if (r_lat_cnt == 2'd0) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Datapath: priority toggle, write data capture, sticky flags, latency counter and display capture
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prio       <= PRIO_WR;
            r_wr_data    <= '0;
            r_disp_data  <= '0;
            r_disp_valid <= 1'b0;
            r_err_full   <= 1'b0;
            r_err_empty  <= 1'b0;
            r_lat_cnt    <= 2'd0;
        end else begin
            if (w_toggle_prio) begin
                r_prio <= (r_prio == PRIO_WR) ? PRIO_RD : PRIO_WR;
            end
            if (w_grant_wr) begin
                r_wr_data <= i_sw_data;
            end
            if (w_set_err_full) begin
                r_err_full <= 1'b1;
            end else if (r_state == WRITE) begin
                r_err_full <= 1'b0;
            end
            if (w_set_err_empty) begin
                r_err_empty <= 1'b1;
            end else if (r_state == READ) begin
                r_err_empty <= 1'b0;
            end
            if (r_state == READ) begin
                r_lat_cnt <= LAT_INIT;
            end else if ((r_state == RD_WAIT) && (r_lat_cnt != 2'd0)) begin
                r_lat_cnt <= r_lat_cnt - 2'd1;
            end
            if ((r_state == RD_WAIT) && (r_lat_cnt == 2'd0)) begin
                r_disp_data  <= i_rd_data;
                r_disp_valid <= 1'b1;
            end
        end
    end

endmodule

// File: doc/fifo_button_ctrl.md
Name: fifo_button_ctrl

Overview:
- Sequences FIFO accesses from debounced push-button requests on a board-level FIFO demo.
- Sits between the two debounce blocks (write and read buttons, outputs held high for roughly one slow-tick period) and the FIFO write/read ports. All signals are in the `clk` domain.
- Converts stretched button pulses into single-cycle `wr_en`/`rd_en` strobes, gated by `full`/`empty`.
- Arbitrates simultaneous requests, captures read data for display, and flags rejected operations.

Parameters:
- DATA_W, 8, width of the switch data and the FIFO data.
- RD_LAT, 1, cycles from `rd_en` to valid `rd_data`; legal range 0..3.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- wr_btn  in  1  debounced write request; a level that stays high for many cycles.
- rd_btn  in  1  debounced read request; a level that stays high for many cycles.
- sw_data  in  DATA_W  data to write, taken from the switches.
- full  in  1  FIFO full, write side.
- empty  in  1  FIFO empty, read side.
- rd_data  in  DATA_W  FIFO read data.
- wr_en  out  1  single-cycle FIFO write strobe.
- wr_data  out  DATA_W  data presented with `wr_en`.
- rd_en  out  1  single-cycle FIFO read strobe.
- disp_data  out  DATA_W  last value read, held for display.
- disp_valid  out  1  high once at least one read has completed.
- err_full  out  1  sticky: last write request was rejected because the FIFO was full.
- err_empty  out  1  sticky: last read request was rejected because the FIFO was empty.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, `prio` = 0 (write has priority), button edge registers 0.
- Edge detect:
  - `wr_rise = wr_btn & ~wr_btn_q`; `rd_rise` likewise.
  - A rise is latched into a pending bit (`wr_pend` / `rd_pend`).
  - A pending bit clears when its request is served or rejected.
  - A level held high never generates a second request.
- FSM states: IDLE, WRITE, READ, RD_WAIT.
- IDLE:
  - If both pending, grant the side selected by `prio`, then toggle `prio`. The other request stays pending and is served next.
  - If only one is pending, grant it. `prio` is unchanged.
- Write grant:
  - `full` = 1: `err_full` <= 1, no strobe, clear `wr_pend`, stay in IDLE.
  - Otherwise go to WRITE.
- WRITE (1 cycle):
  - `wr_en` = 1, `wr_data` = `sw_data` registered at grant.
  - Clear `err_full`, clear `wr_pend`, return to IDLE.
- Read grant:
  - `empty` = 1: `err_empty` <= 1, clear `rd_pend`, stay in IDLE.
  - Otherwise go to READ.
- READ (1 cycle):
  - `rd_en` = 1, clear `err_empty`, clear `rd_pend`.
  - Load the latency counter with RD_LAT, then go to RD_WAIT.
- RD_WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, capture `disp_data` <= `rd_data`, set `disp_valid` = 1, return to IDLE.
  - With RD_LAT = 0, capture occurs in the first RD_WAIT cycle.
- Latencies:
  - Button rise to `wr_en`: 3 cycles (edge register, grant, WRITE).
  - Button rise to `disp_data` update: 3 + RD_LAT + 1 cycles.
- Back-to-back operations: at least one IDLE cycle between consecutive strobes.
- `wr_en` and `rd_en` are never high in the same cycle.
- Rises arriving while not in IDLE are latched into pending and served afterwards.
- `full`/`empty` are sampled only at grant.
- Reset mid-operation: the FSM aborts to IDLE, pending bits, sticky flags and `disp_valid` clear, and no strobe is issued in the reset cycle.
- `busy` = (state != IDLE).

Optional Feature:
- Macro: FIFO_LEVEL_TRACK_EN.
- Defined:
  - Extra output `level` [ADDR_W:0] and extra parameter ADDR_W (default 4).
  - `level` increments on each `wr_en` and decrements on each `rd_en`, saturating at 0 and at 2^ADDR_W.
  - `level` resets to 0.
  - A write grant is also rejected (setting `err_full`) when `level` == 2^ADDR_W. A read grant is also rejected (setting `err_empty`) when `level` == 0.
- Not defined: no `level` port; gating uses `full`/`empty` only.

Decomposition:
- Package `fifo_ctrl_pkg`:
  - FSM state enum (IDLE/WRITE/READ/RD_WAIT).
  - Constants `PRIO_WR` = 0, `PRIO_RD` = 1.
  - Default DATA_W.
- Sub-module `req_edge_latch`, instanced twice (write and read):
  - Performs edge detect plus the pending bit.
  - Ports: `clk`, `reset`, `btn`, `clr`, `pend`.

Test Plan:
- Write: `wr_btn` high 50 cycles with `sw_data` = 0xA5, `full` = 0 -> exactly one `wr_en` pulse, 3 cycles after the rise, with `wr_data` = 0xA5.
- Read: RD_LAT = 1, `empty` = 0, `rd_data` = 0x3C valid 1 cycle after `rd_en`, pulse `rd_btn` -> one `rd_en`, then `disp_data` = 0x3C and `disp_valid` = 1 two cycles after `rd_en`.
- Simultaneous: `wr_btn` and `rd_btn` rise in the same cycle from reset -> WRITE first, READ second, separated by one IDLE cycle. Repeat -> READ first (`prio` toggled).
- Rejects:
  - `full` = 1 with a write press -> no `wr_en`, `err_full` = 1.
  - A later accepted write clears `err_full`.
  - `empty` = 1 with a read press -> `err_empty` = 1, no `rd_en`.
- Reset: assert `reset` during RD_WAIT -> no `disp_data` capture, all outputs 0 the next cycle, and a new press afterwards is served normally.
- FIFO_LEVEL_TRACK_EN (ADDR_W = 2): 5 write presses -> `level` = 4, 5th rejected with `err_full`; 5 read presses -> `level` = 0, 5th rejected with `err_empty`.
